// File: rtl/uart_pixel_packer_pkg.sv
// Shared definitions for the UART pixel path: byte-format encodings, bytes-per-pixel
// lookup and the zero-fill, MSB-aligned expansions to RGB888.
package uart_pixel_packer_pkg;

   localparam logic [1:0] MODE_RGB332 = 2'd0;
   localparam logic [1:0] MODE_RGB565 = 2'd1;
   localparam logic [1:0] MODE_RGB888 = 2'd2;

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      ASSEMBLE  = 1'b1
   } state_t;

   // The reserved encoding behaves exactly like RGB332.
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_RGB332 : m;
   endfunction

   function automatic logic [1:0] bpp(input logic [1:0] m);
      case (m)
         MODE_RGB565: return 2'd2;
         MODE_RGB888: return 2'd3;
         default:     return 2'd1;
      endcase
   endfunction

   function automatic logic [23:0] expand_332(input logic [7:0] b);
      return {b[7:5], 5'b0, b[4:2], 5'b0, b[1:0], 6'b0};
   endfunction

   function automatic logic [23:0] expand_565(input logic [15:0] w);
      return {w[15:11], 3'b0, w[10:5], 2'b0, w[4:0], 3'b0};
   endfunction

endpackage

// File: rtl/uart_pixel_packer_pix_expand.sv
// Combinational conversion of up to three raw bytes into an RGB888 pixel, selected by format.
module pix_expand
   import uart_pixel_packer_pkg::*;
(
   input  logic [1:0]  mode,
   input  logic [7:0]  byte0,
   input  logic [7:0]  byte1,
   input  logic [7:0]  byte2,
   output logic [23:0] rgb
);

   always_comb begin
      case (mode)
         MODE_RGB565: rgb = expand_565({byte0, byte1});
         MODE_RGB888: rgb = {byte0, byte1, byte2};
         default:     rgb = expand_332(byte0);
      endcase
   end

endmodule

// File: rtl/uart_pixel_packer.sv
// Packs UART receive bytes into RGB888 pixels with optional frame sync, inter-byte
// timeout, FIFO overflow tracking and per-frame pixel counting.
module uart_pixel_packer
   import uart_pixel_packer_pkg::*;
#(
   parameter int         PIX_W       = 24,
   parameter int         IMG_W       = 640,
   parameter int         IMG_H       = 480,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic                               sclk,
   input  logic                               s_rst_n,
   input  logic [7:0]                         rx_data,
   input  logic                               rx_flag,
   input  logic [1:0]                         mode,
   input  logic                               sync_en,
   input  logic                               wfifo_full,
   output logic [PIX_W-1:0]                   pix_data,
   output logic                               pix_valid,
   output logic                               frame_start,
   output logic                               frame_done,
   output logic                               overflow,
   output logic [$clog2(IMG_W*IMG_H)-1:0]     pix_cnt
);

   localparam int CNT_W = $clog2(IMG_W*IMG_H);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   state_t               state_reg, state_next;
   logic [1:0]           mode_reg, mode_next;
   logic [1:0]           k_reg, k_next;
   logic [TMR_W-1:0]     timer_reg, timer_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [7:0]           byte_reg [3];
   logic [7:0]           byte_cur [3];
   logic [PIX_W-1:0]     pix_data_reg, pix_data_next;
   logic                 pix_valid_reg, pix_valid_next;
   logic                 frame_start_reg, frame_start_next;
   logic                 frame_done_reg, frame_done_next;
   logic                 overflow_reg, overflow_next;

   logic                 frame_go, take, last_byte;
   logic [1:0]           eff_mode;
   logic [23:0]          rgb;

   // The byte that starts a frame must already be assembled with the new frame's format.
   always_comb begin
      frame_go = 1'b0;
      take     = 1'b0;
      eff_mode = mode_reg;
      if (rx_flag) begin
         if (state_reg == WAIT_SYNC) begin
            frame_go = !sync_en || (rx_data == SYNC_BYTE);
            take     = !sync_en;
            eff_mode = norm_mode(mode);
         end else begin
            take = 1'b1;
         end
      end
      last_byte = take && (k_reg == bpp(eff_mode) - 2'd1);
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_byte
      assign byte_cur[gi] = (take && k_reg == 2'(gi)) ? rx_data : byte_reg[gi];
   end

   pix_expand u_expand (
      .mode  (eff_mode),
      .byte0 (byte_cur[0]),
      .byte1 (byte_cur[1]),
      .byte2 (byte_cur[2]),
      .rgb   (rgb)
   );

   always_comb begin
      state_next       = state_reg;
      mode_next        = mode_reg;
      k_next           = k_reg;
      timer_next       = timer_reg;
      cnt_next         = cnt_reg;
      overflow_next    = overflow_reg;
      pix_data_next    = pix_data_reg;
      pix_valid_next   = 1'b0;
      frame_start_next = 1'b0;
      frame_done_next  = 1'b0;

      if (frame_go) begin
         state_next       = ASSEMBLE;
         mode_next        = eff_mode;
         frame_start_next = 1'b1;
         overflow_next    = 1'b0;
      end

      if (take) k_next = k_reg + 2'd1;

      // A dropped pixel still advances the count so line/frame geometry stays intact.
      if (last_byte) begin
         k_next         = 2'd0;
         pix_data_next  = rgb;
         pix_valid_next = !wfifo_full;
         if (wfifo_full) overflow_next = 1'b1;
         if (cnt_reg == CNT_W'(IMG_W*IMG_H - 1)) begin
            cnt_next        = '0;
            frame_done_next = 1'b1;
            state_next      = WAIT_SYNC;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end

      if (rx_flag || k_reg == 2'd0) begin
         timer_next = '0;
      end else if (timer_reg == TMR_W'(TIMEOUT_CYC - 1)) begin
         timer_next = '0;
         k_next     = 2'd0;
      end else begin
         timer_next = timer_reg + 1'b1;
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_reg       <= WAIT_SYNC;
         mode_reg        <= MODE_RGB332;
         k_reg           <= 2'd0;
         timer_reg       <= '0;
         cnt_reg         <= '0;
         byte_reg        <= '{default: 8'h00};
         pix_data_reg    <= '0;
         pix_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
         overflow_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         mode_reg        <= mode_next;
         k_reg           <= k_next;
         timer_reg       <= timer_next;
         cnt_reg         <= cnt_next;
         byte_reg        <= byte_cur;
         pix_data_reg    <= pix_data_next;
         pix_valid_reg   <= pix_valid_next;
         frame_start_reg <= frame_start_next;
         frame_done_reg  <= frame_done_next;
         overflow_reg    <= overflow_next;
      end
   end

   assign pix_data    = pix_data_reg;
   assign pix_valid   = pix_valid_reg;
   assign frame_start = frame_start_reg;
   assign frame_done  = frame_done_reg;
   assign overflow    = overflow_reg;
   assign pix_cnt     = cnt_reg;

endmodule
